// File: rtl/fwd_hazard_ctrl_if.sv
// Bundles the EX/ID pipeline signals, the stall/bypass outputs and the stall
// statistics of the forwarding and hazard controller.
interface fwd_hazard_ctrl_if #(
  parameter int AW   = 5,
  parameter int NSTG = 3
);
  localparam int SW = $clog2(NSTG + 1);

  logic          ex_valid;
  logic          ex_regwrite;
  logic          ex_is_load;
  logic [AW-1:0] ex_rd;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          flush;
  logic          stall;
  logic [SW-1:0] fwd_a;
  logic [SW-1:0] fwd_b;
  logic [3:0]    stall_run;
  logic [15:0]   stall_total;

  modport master (
    output ex_valid, ex_regwrite, ex_is_load, ex_rd, id_valid, id_rs, id_rt, flush,
    input  stall, fwd_a, fwd_b, stall_run, stall_total
  );

  modport slave (
    input  ex_valid, ex_regwrite, ex_is_load, ex_rd, id_valid, id_rs, id_rt, flush,
    output stall, fwd_a, fwd_b, stall_run, stall_total
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the EX stage: tracks in-flight
// destination registers, produces registered bypass selects and a load-use stall.
module fwd_hazard_ctrl #(
  parameter int AW       = 5,
  parameter int NSTG     = 3,
  parameter int LOAD_RDY = 2
) (
  input logic               clk,
  input logic               rst_n,
  fwd_hazard_ctrl_if.slave  bus
);
  localparam int SW = $clog2(NSTG + 1);

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StStall = 1'b1;

  logic [NSTG-1:0]         v_q, v_d;
  logic [NSTG-1:0]         ld_q, ld_d;
  logic [NSTG-1:0][AW-1:0] rd_q, rd_d;
  logic [SW-1:0]           fwd_a_q, fwd_a_d;
  logic [SW-1:0]           fwd_b_q, fwd_b_d;
  logic [0:0]              state_q, state_d;
  logic [3:0]              stall_run_q, stall_run_d;
  logic [15:0]             stall_total_q, stall_total_d;

  logic                    ex_cand;
  logic [1:0][AW-1:0]      src;
  logic [1:0][SW-1:0]      sel;
  logic [1:0]              haz;
  logic                    stall;

  assign ex_cand = bus.ex_valid & bus.ex_regwrite & (bus.ex_rd != '0);
  assign src[0]  = bus.id_rs;
  assign src[1]  = bus.id_rt;

  // Scan oldest candidate first so the youngest match overwrites it.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      sel[s] = '0;
      haz[s] = 1'b0;
      for (int k = NSTG - 1; k >= 1; k--) begin
        if (v_q[k-1] && (rd_q[k-1] == src[s])) begin
          sel[s] = SW'(k + 1);
          haz[s] = ld_q[k-1] && ((k + 1) < LOAD_RDY);
        end
      end
      if (ex_cand && (bus.ex_rd == src[s])) begin
        sel[s] = SW'(1);
        haz[s] = bus.ex_is_load && (1 < LOAD_RDY);
      end
      if (src[s] == '0) begin
        sel[s] = '0;
        haz[s] = 1'b0;
      end
    end
  end

  // Gated by rst_n so no stall is visible while the block is held in reset.
  assign stall = rst_n & bus.id_valid & ~bus.flush & (|haz);

  always_comb begin
    v_d[0]  = ex_cand;
    ld_d[0] = bus.ex_is_load;
    rd_d[0] = bus.ex_rd;
    for (int k = 1; k < NSTG; k++) begin
      v_d[k]  = v_q[k-1] & ~bus.flush;
      ld_d[k] = ld_q[k-1];
      rd_d[k] = rd_q[k-1];
    end
  end

  always_comb begin
    if (bus.flush || stall || !bus.id_valid) begin
      fwd_a_d = '0;
      fwd_b_d = '0;
    end else begin
      fwd_a_d = sel[0];
      fwd_b_d = sel[1];
    end
  end

  always_comb begin
    state_d       = state_q;
    stall_run_d   = stall_run_q;
    stall_total_d = stall_total_q;
    case (state_q)
      StRun: begin
        if (stall) begin
          state_d     = StStall;
          stall_run_d = 4'd1;
        end else begin
          stall_run_d = 4'd0;
        end
      end
      StStall: begin
        if (stall) begin
          if (stall_run_q != 4'hF) stall_run_d = stall_run_q + 4'd1;
        end else begin
          state_d     = StRun;
          stall_run_d = 4'd0;
        end
      end
      default: begin
        state_d     = StRun;
        stall_run_d = 4'd0;
      end
    endcase
    if (stall && (stall_total_q != 16'hFFFF)) stall_total_d = stall_total_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q           <= '0;
      ld_q          <= '0;
      rd_q          <= '0;
      fwd_a_q       <= '0;
      fwd_b_q       <= '0;
      state_q       <= StRun;
      stall_run_q   <= '0;
      stall_total_q <= '0;
    end else begin
      v_q           <= v_d;
      ld_q          <= ld_d;
      rd_q          <= rd_d;
      fwd_a_q       <= fwd_a_d;
      fwd_b_q       <= fwd_b_d;
      state_q       <= state_d;
      stall_run_q   <= stall_run_d;
      stall_total_q <= stall_total_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.fwd_a       = fwd_a_q;
  assign bus.fwd_b       = fwd_b_q;
  assign bus.stall_run   = stall_run_q;
  assign bus.stall_total = stall_total_q;
endmodule
